axi4_burst_addr_gen: RTL and testbench

Synthesisable AXI4 burst address generator: accepts one burst request (start address, AxLEN, AxSIZE, AxBURST, ID) and emits one beat descriptor per cycle carrying beat address, byte-lane strobe, beat index and last flag. Supports FIXED, INCR and WRAP bursts across parametrised address and data widths. Illegal requests are flagged with a coded error pulse and produce no beats. It sits behind the slave-side address channels of the AVIP (AW/AR capture) and feeds the memory model and data-channel logic with the AXI4 burst/size/response encodings used throughout the environment.

---
 rtl/axi4_burst_addr_gen.sv | 165 ++++++++++++++++
 tb/tb_axi4_burst_addr_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: validates a burst request, then emits one
// beat descriptor (address, byte strobe, index, last) per accepted cycle.
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [7:0]               req_len,
  input  logic [2:0]               req_size,
  input  logic [1:0]               req_burst,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [DATA_WIDTH/8-1:0]  beat_strb,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [7:0]               beat_idx,
  output logic                     beat_last,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFFW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int MAX_SIZE = $clog2(NB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0] cur_addr, wrap_lo, wrap_end;
  logic [7:0]               len_q, idx_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic                     err_valid_q;
  logic [2:0]               err_code_q;

  logic                     accept, req_legal, last_q;
  logic [2:0]               req_err;
  logic [ADDRESS_WIDTH-1:0] req_bytes, req_mask, req_span, req_wrap_lo;
  logic [11:0]              req_aligned_lo;
  logic [16:0]              span17, end4k;
  logic [ADDRESS_WIDTH-1:0] cur_bytes, cur_mask, cur_aligned, wrap_step, next_addr;
  logic [OFFW-1:0]          lo_off, al_off;

  // Request decode: byte count, wrap window and 4 KB end point
  always_comb begin
    req_bytes      = ADDRESS_WIDTH'(1) << req_size;
    req_mask       = req_bytes - ADDRESS_WIDTH'(1);
    req_span       = ADDRESS_WIDTH'({1'b0, req_len} + 9'd1) << req_size;
    req_wrap_lo    = req_addr & ~(req_span - ADDRESS_WIDTH'(1));
    req_aligned_lo = req_addr[11:0] & ~req_mask[11:0];
    span17         = 17'({1'b0, req_len} + 9'd1) << req_size;
    end4k          = {5'b0, req_aligned_lo} + span17;

    req_err = 3'd0;
    if (req_burst == 2'b11)
      req_err = 3'd1;
    else if (req_size > 3'(MAX_SIZE))
      req_err = 3'd2;
    else if (req_burst == BURST_WRAP && !(req_len == 8'd1 || req_len == 8'd3 ||
                                          req_len == 8'd7 || req_len == 8'd15))
      req_err = 3'd3;
    else if (req_burst == BURST_WRAP && (req_addr & req_mask) != '0)
      req_err = 3'd4;
    else if (req_burst == BURST_INCR && end4k > 17'd4096)
      req_err = 3'd5;
    req_legal = (req_err == 3'd0);
  end

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE) && !areset;
    accept     = req_valid && req_ready;
    last_q     = (idx_q == len_q);
    case (state)
      IDLE:    if (accept && req_legal) state_next = BURST;
      BURST:   if (beat_ready && last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Beat address sequencing
  always_comb begin
    cur_bytes   = ADDRESS_WIDTH'(1) << size_q;
    cur_mask    = cur_bytes - ADDRESS_WIDTH'(1);
    cur_aligned = cur_addr & ~cur_mask;
    wrap_step   = cur_addr + cur_bytes;
    case (burst_q)
      BURST_INCR:  next_addr = cur_aligned + cur_bytes;
      BURST_WRAP:  next_addr = (wrap_step == wrap_end) ? wrap_lo : wrap_step;
      BURST_FIXED: next_addr = cur_addr;
      default:     next_addr = cur_addr;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cur_addr    <= '0;
      wrap_lo     <= '0;
      wrap_end    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      id_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      err_valid_q <= accept && !req_legal;
      err_code_q  <= (accept && !req_legal) ? req_err : 3'd0;
      if (accept && req_legal) begin
        cur_addr <= req_addr;
        wrap_lo  <= req_wrap_lo;
        wrap_end <= req_wrap_lo + req_span;
        len_q    <= req_len;
        idx_q    <= '0;
        size_q   <= req_size;
        burst_q  <= req_burst;
        id_q     <= req_id;
      end else if (state == BURST && beat_ready && !last_q) begin
        idx_q    <= idx_q + 8'd1;
        cur_addr <= next_addr;
      end
    end
  end

  // Strobe spans from the unaligned start lane to the end of the aligned beat
  always_comb begin
    int unsigned lo_i, hi_i;
    beat_strb = '0;
    lo_off    = cur_addr[OFFW-1:0] & OFFW'(NB - 1);
    al_off    = cur_aligned[OFFW-1:0] & OFFW'(NB - 1);
    lo_i      = int'(lo_off);
    hi_i      = int'(al_off) + (32'd1 << size_q) - 32'd1;
    for (int unsigned i = 0; i < NB; i++)
      beat_strb[i] = (state == BURST) && (i >= lo_i) && (i <= hi_i);
  end

  assign busy       = (state == BURST);
  assign beat_valid = busy;
  assign beat_addr  = busy ? cur_addr : '0;
  assign beat_id    = busy ? id_q : '0;
  assign beat_idx   = busy ? idx_q : '0;
  assign beat_last  = busy && last_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed self-checking bench for axi4_burst_addr_gen (32-bit data bus).
module tb_axi4_burst_addr_gen;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_id = '0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_len = '0;
  logic [2:0]    req_size = '0;
  logic [1:0]    req_burst = '0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [AW-1:0] beat_addr;
  logic [DW/8-1:0] beat_strb;
  logic [IW-1:0] beat_id;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic          err_valid;
  logic [2:0]    err_code;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  axi4_burst_addr_gen #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_id(beat_id), .beat_idx(beat_idx), .beat_last(beat_last),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    req_id = id; req_addr = addr; req_len = len; req_size = size; req_burst = burst;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    beat_ready = 1'b0;
    repeat (2) tick();
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_ready got %b exp 0", req_ready);
    end
    vectors++;
    if ({beat_valid, beat_last, err_valid, busy, err_code} !== 7'b0 ||
        beat_addr !== '0 || beat_strb !== '0 || beat_id !== '0 || beat_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got v%b l%b e%b b%b c%0d a%h s%h id%h i%0d exp all 0",
               beat_valid, beat_last, err_valid, busy, err_code, beat_addr, beat_strb,
               beat_id, beat_idx);
    end
    areset = 1'b0;
    tick();
    vectors++;
    if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got ready %b valid %b exp 1 0", req_ready, beat_valid);
    end
  endtask

  task automatic test_bursts();
    logic [31:0] sa [7] = '{32'h1000, 32'h1001, 32'h0008, 32'h0022, 32'h0013, 32'h0FFE, 32'h0016};
    logic [7:0]  sl [7] = '{8'd3, 8'd1, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic [2:0]  sz [7] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [1:0]  sb [7] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
    logic [31:0] ea [7][4] = '{
      '{32'h1000, 32'h1004, 32'h1008, 32'h100C},
      '{32'h1001, 32'h1004, 32'h0, 32'h0},
      '{32'h0008, 32'h000C, 32'h0000, 32'h0004},
      '{32'h0022, 32'h0022, 32'h0022, 32'h0},
      '{32'h0013, 32'h0014, 32'h0, 32'h0},
      '{32'h0FFE, 32'h0, 32'h0, 32'h0},
      '{32'h0016, 32'h0010, 32'h0012, 32'h0014}};
    logic [3:0]  es [7][4] = '{
      '{4'hF, 4'hF, 4'hF, 4'hF},
      '{4'hE, 4'hF, 4'h0, 4'h0},
      '{4'hF, 4'hF, 4'hF, 4'hF},
      '{4'h4, 4'h4, 4'h4, 4'h0},
      '{4'h8, 4'h1, 4'h0, 4'h0},
      '{4'hC, 4'h0, 4'h0, 4'h0},
      '{4'hC, 4'h3, 4'hC, 4'h3}};
    beat_ready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      send_req(IW'(16'hA0 + s), sa[s], sl[s], sz[s], sb[s]);
      for (int b = 0; b <= int'(sl[s]); b++) begin
        vectors++;
        if (beat_valid !== 1'b1 || busy !== 1'b1 || err_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL burst_valid s%0d b%0d got v%b busy%b e%b exp 1 1 0",
                   s, b, beat_valid, busy, err_valid);
        end
        vectors++;
        if (beat_addr !== ea[s][b] || beat_strb !== es[s][b]) begin
          miscompares++;
          $display("FAIL burst_addr s%0d b%0d got %h/%h exp %h/%h",
                   s, b, beat_addr, beat_strb, ea[s][b], es[s][b]);
        end
        vectors++;
        if (beat_idx !== 8'(b) || beat_last !== (b == int'(sl[s])) ||
            beat_id !== IW'(16'hA0 + s)) begin
          miscompares++;
          $display("FAIL burst_idx s%0d b%0d got idx%0d last%b id%h exp idx%0d last%b id%h",
                   s, b, beat_idx, beat_last, beat_id, b, (b == int'(sl[s])), 16'hA0 + s);
        end
        tick();
      end
      vectors++;
      if (beat_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL burst_end s%0d got v%b busy%b ready%b exp 0 0 1",
                 s, beat_valid, busy, req_ready);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] sa [8] = '{32'h100, 32'h0, 32'h0, 32'h2, 32'h0FFC, 32'h0, 32'h0, 32'h2};
    logic [7:0]  sl [8] = '{8'd0, 8'd0, 8'd2, 8'd3, 8'd1, 8'd0, 8'd2, 8'd2};
    logic [2:0]  sz [8] = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
    logic [1:0]  sb [8] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [2:0]  ec [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3};
    beat_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      send_req(IW'(16'hE0 + s), sa[s], sl[s], sz[s], sb[s]);
      vectors++;
      if (err_valid !== 1'b1 || err_code !== ec[s]) begin
        miscompares++;
        $display("FAIL err_code case%0d got v%b code%0d exp 1 code%0d", s, err_valid, err_code, ec[s]);
      end
      vectors++;
      if (beat_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL err_nobeat case%0d got v%b busy%b ready%b exp 0 0 1",
                 s, beat_valid, busy, req_ready);
      end
      tick();
      vectors++;
      if (err_valid !== 1'b0 || beat_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_pulse case%0d got err%b beat%b exp 0 0", s, err_valid, beat_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    beat_ready = 1'b1;
    send_req(16'hB0, 32'h2000, 8'd3, 3'd2, 2'b01);
    for (int b = 0; b < 4; b++) begin
      beat_ready = (b != 1);
      for (int h = 0; h < ((b == 1) ? 4 : 1); h++) begin
        if (b == 1 && h == 3) beat_ready = 1'b1;
        vectors++;
        if (beat_valid !== 1'b1 || beat_addr !== exp_a[b] || beat_idx !== 8'(b) ||
            beat_strb !== 4'hF || beat_last !== (b == 3) || beat_id !== 16'hB0) begin
          miscompares++;
          $display("FAIL backpressure b%0d h%0d got v%b a%h i%0d s%h l%b exp 1 a%h i%0d sF l%b",
                   b, h, beat_valid, beat_addr, beat_idx, beat_strb, beat_last, exp_a[b], b, (b == 3));
        end
        tick();
      end
    end
    vectors++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_end got v%b ready%b exp 0 1", beat_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    beat_ready = 1'b1;
    req_id = 16'hC1; req_addr = 32'h40; req_len = 8'd0; req_size = 3'd2; req_burst = 2'b01;
    req_valid = 1'b1;
    tick();
    req_id = 16'hC2; req_addr = 32'h80;
    vectors++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h40 || beat_last !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first got v%b a%h l%b ready%b exp 1 a40 1 0",
               beat_valid, beat_addr, beat_last, req_ready);
    end
    tick();
    vectors++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap got v%b ready%b exp 0 1", beat_valid, req_ready);
    end
    tick();
    req_valid = 1'b0;
    vectors++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h80 || beat_idx !== 8'd0 || beat_id !== 16'hC2) begin
      miscompares++;
      $display("FAIL b2b_second got v%b a%h i%0d id%h exp 1 a80 0 C2",
               beat_valid, beat_addr, beat_idx, beat_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    beat_ready = 1'b1;
    send_req(16'hD0, 32'h3000, 8'd7, 3'd2, 2'b01);
    tick();
    vectors++;
    if (beat_idx !== 8'd1 || beat_addr !== 32'h3004) begin
      miscompares++;
      $display("FAIL midrst_pre got i%0d a%h exp 1 a3004", beat_idx, beat_addr);
    end
    areset = 1'b1;
    tick();
    vectors++;
    if ({beat_valid, beat_last, busy, err_valid, req_ready} !== 5'b0 ||
        beat_addr !== '0 || beat_strb !== '0 || beat_idx !== '0 || beat_id !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs got v%b l%b b%b e%b r%b a%h s%h i%0d id%h exp all 0",
               beat_valid, beat_last, busy, err_valid, req_ready, beat_addr, beat_strb,
               beat_idx, beat_id);
    end
    areset = 1'b0;
    tick();
    vectors++;
    if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_release got ready%b v%b exp 1 0", req_ready, beat_valid);
    end
    send_req(16'hD1, 32'h3100, 8'd1, 3'd2, 2'b01);
    vectors++;
    if (beat_valid !== 1'b1 || beat_idx !== 8'd0 || beat_addr !== 32'h3100 || beat_id !== 16'hD1) begin
      miscompares++;
      $display("FAIL midrst_restart got v%b i%0d a%h id%h exp 1 0 a3100 D1",
               beat_valid, beat_idx, beat_addr, beat_id);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_bursts();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
